// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants (640x480@60) used as parameter defaults,
// plus the helper that forms an axis total from its four segments.
package vga_timing_pkg;

    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FP      = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BP      = 48;

    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FP      = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BP      = 33;

    localparam int unsigned VGA_COUNT_W   = 11;
    localparam int unsigned VGA_CLK_DIV   = 4;

    function automatic int unsigned axis_total(
        input int unsigned visible,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return visible + fp + sync + bp;
    endfunction

    localparam int unsigned VGA_H_TOTAL =
        axis_total(VGA_H_VISIBLE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int unsigned VGA_V_TOTAL =
        axis_total(VGA_V_VISIBLE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync and
// visible-window decode evaluated on the next-state count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned VISIBLE  = VGA_H_VISIBLE,
    parameter int unsigned FP       = VGA_H_FP,
    parameter int unsigned SYNC     = VGA_H_SYNC,
    parameter int unsigned BP       = VGA_H_BP,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned WIDTH    = VGA_COUNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             advance,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             sync,
    output logic             visible
);

    localparam int unsigned      TOTAL      = axis_total(VISIBLE, FP, SYNC, BP);
    localparam logic [WIDTH-1:0] LAST       = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] SYNC_START = WIDTH'(VISIBLE + FP);
    localparam logic [WIDTH-1:0] SYNC_END   = WIDTH'(VISIBLE + FP + SYNC);
    localparam logic [WIDTH-1:0] VIS_END    = WIDTH'(VISIBLE);

    logic [WIDTH-1:0] count_q, count_d;
    logic             sync_q, sync_d;
    logic             vis_q, vis_d;

    // step gates the decode registers separately from advance so the
    // vertical decode still refreshes on pixels that do not move the line.
    always_comb begin
        count_d = count_q;
        sync_d  = sync_q;
        vis_d   = vis_q;
        wrap    = advance && (count_q == LAST);
        if (advance) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
        if (step) begin
            sync_d = ((count_d >= SYNC_START) && (count_d < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
            vis_d  = (count_d < VIS_END);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            sync_q  <= ~SYNC_POL;
            vis_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
            vis_q   <= vis_d;
        end
    end

    assign count   = count_q;
    assign sync    = sync_q;
    assign visible = vis_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: pixel-clock divider feeding a
// chained horizontal/vertical counter pair with registered decodes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP,
    parameter bit          SYNC_POL  = 1'b0,
    parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
    parameter int unsigned bitDim    = VGA_COUNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [bitDim-1:0] h_count,
    output logic [bitDim-1:0] v_count,
    output logic              hsync,
    output logic              vsync,
    output logic              video_on,
    output logic              pix_en,
    output logic              frame_start
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_q, pix_d;
    logic             frame_q, frame_d;
    logic             tick;
    logic             h_wrap, v_wrap;
    logic             h_vis, v_vis;

    always_comb begin
        div_d   = div_q;
        tick    = en && (div_q == DIV_LAST);
        if (en) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
        pix_d   = tick;
        // v_wrap already implies h_wrap and tick, i.e. (H_TOTAL-1, V_TOTAL-1) -> (0,0)
        frame_d = v_wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            pix_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            pix_q   <= pix_d;
            frame_q <= frame_d;
        end
    end

    vga_axis_counter #(
        .VISIBLE  (H_VISIBLE),
        .FP       (H_FP),
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .SYNC_POL (SYNC_POL),
        .WIDTH    (bitDim)
    ) u_h_axis (
        .clk      (clk),
        .rst      (rst),
        .step     (tick),
        .advance  (tick),
        .count    (h_count),
        .wrap     (h_wrap),
        .sync     (hsync),
        .visible  (h_vis)
    );

    vga_axis_counter #(
        .VISIBLE  (V_VISIBLE),
        .FP       (V_FP),
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .SYNC_POL (SYNC_POL),
        .WIDTH    (bitDim)
    ) u_v_axis (
        .clk      (clk),
        .rst      (rst),
        .step     (tick),
        .advance  (h_wrap),
        .count    (v_count),
        .wrap     (v_wrap),
        .sync     (vsync),
        .visible  (v_vis)
    );

    // Strobes are forced low while paused even if the registered tick is still set.
    assign pix_en      = pix_q && en;
    assign frame_start = frame_q && en;
    assign video_on    = h_vis && v_vis;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default 640x480 CLK_DIV=4 instance and a tiny-raster
// CLK_DIV=1 instance with active-high syncs, checked pixel strobe by strobe.
module tb_vga_timing_gen;

    localparam int A_W = 11;
    localparam int B_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           a_rst, a_en, a_hs, a_vs, a_vid, a_pix, a_fs;
    logic [A_W-1:0] a_h, a_v;
    logic           b_rst, b_en, b_hs, b_vs, b_vid, b_pix, b_fs;
    logic [B_W-1:0] b_h, b_v;

    vga_timing_gen dut_a (
        .clk (clk), .rst (a_rst), .en (a_en),
        .h_count (a_h), .v_count (a_v),
        .hsync (a_hs), .vsync (a_vs), .video_on (a_vid),
        .pix_en (a_pix), .frame_start (a_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_VISIBLE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_POL (1'b1), .CLK_DIV (1), .bitDim (B_W)
    ) dut_b (
        .clk (clk), .rst (b_rst), .en (b_en),
        .h_count (b_h), .v_count (b_v),
        .hsync (b_hs), .vsync (b_vs), .video_on (b_vid),
        .pix_en (b_pix), .frame_start (b_fs)
    );

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic        hs;
        logic        vs;
        logic        vid;
        logic        fs;
    } pix_t;

    pix_t q_a[$];
    pix_t q_b[$];
    pix_t ea, aa, eb, ab;

    int checks = 0;
    int errors = 0;

    // line-0 observations on instance A, and frame observations on B
    int a_hs_low = 0, a_hs_first = -1, a_hs_last = -1, a_vid_fall = -1;
    int b_cyc = 0, b_last_fs = -1, b_fs_cnt = 0, b_vs_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_pix(input string name, input pix_t e, input pix_t a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got h=%0d v=%0d hs=%0b vs=%0b vid=%0b fs=%0b expected h=%0d v=%0d hs=%0b vs=%0b vid=%0b fs=%0b",
                     name, a.h, a.v, a.hs, a.vs, a.vid, a.fs, e.h, e.v, e.hs, e.vs, e.vid, e.fs);
        end
    endtask

    // Expected raster state for the n-th pixel strobe since reset release.
    function automatic pix_t model(input int n, input int ht, input int vt,
                                   input int hv, input int hf, input int hsw,
                                   input int vv, input int vf, input int vsw,
                                   input bit pol);
        pix_t p;
        int pos, h, v;
        pos = n % (ht * vt);
        h = pos % ht;
        v = pos / ht;
        p.h = 16'(h);
        p.v = 16'(v);
        p.hs = (h >= hv + hf && h < hv + hf + hsw) ? pol : !pol;
        p.vs = (v >= vv + vf && v < vv + vf + vsw) ? pol : !pol;
        p.vid = (h < hv) && (v < vv);
        p.fs = (pos == 0);
        return p;
    endfunction

    function automatic pix_t model_a(input int n);
        return model(n, 800, 525, 640, 16, 96, 480, 10, 2, 1'b0);
    endfunction

    function automatic pix_t model_b(input int n);
        return model(n, 15, 10, 8, 2, 3, 6, 1, 2, 1'b1);
    endfunction

    always @(negedge clk) begin
        if (a_pix) begin
            aa.h = 16'(a_h); aa.v = 16'(a_v);
            aa.hs = a_hs; aa.vs = a_vs; aa.vid = a_vid; aa.fs = a_fs;
            if (q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_pix_extra: got strobe at h=%0d v=%0d expected none", a_h, a_v);
            end else begin
                ea = q_a.pop_front();
                cmp_pix("a_pix", ea, aa);
            end
            if (a_v == 0) begin
                if (!a_hs) begin
                    a_hs_low++;
                    if (a_hs_first < 0) a_hs_first = int'(a_h);
                    a_hs_last = int'(a_h);
                end
                if (!a_vid && a_vid_fall < 0) a_vid_fall = int'(a_h);
            end
        end
    end

    always @(negedge clk) begin
        b_cyc++;
        if (b_pix) begin
            ab.h = 16'(b_h); ab.v = 16'(b_v);
            ab.hs = b_hs; ab.vs = b_vs; ab.vid = b_vid; ab.fs = b_fs;
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_pix_extra: got strobe at h=%0d v=%0d expected none", b_h, b_v);
            end else begin
                eb = q_b.pop_front();
                cmp_pix("b_pix", eb, ab);
            end
            if (b_vs) b_vs_cnt++;
            if (b_fs) begin
                if (b_last_fs >= 0) chk("b_frame_period", b_cyc - b_last_fs, 150);
                b_last_fs = b_cyc;
                b_fs_cnt++;
            end
        end
    end

    task automatic run_a();
        int edges;
        a_rst = 1'b1; a_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("a_rst_h", int'(a_h), 0);
        chk("a_rst_v", int'(a_v), 0);
        chk("a_rst_hsync", int'(a_hs), 1);
        chk("a_rst_vsync", int'(a_vs), 1);
        chk("a_rst_video_on", int'(a_vid), 0);
        chk("a_rst_pix_en", int'(a_pix), 0);
        chk("a_rst_frame_start", int'(a_fs), 0);

        for (int n = 1; n <= 1100; n++) q_a.push_back(model_a(n));
        a_rst = 1'b0; a_en = 1'b1;
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); edges++;
            @(negedge clk); #1;
            if (a_pix) break;
        end
        chk("a_first_tick_edges", edges, 4);
        chk("a_first_h", int'(a_h), 1);
        chk("a_first_v", int'(a_v), 0);
        chk("a_first_sync", int'({a_hs, a_vs, a_vid}), 7);

        for (int i = 0; i < 1100 * 4 + 40 && q_a.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        chk("a_drain1", q_a.size(), 0);
        chk("a_pause_h", int'(a_h), 300);
        chk("a_pause_v", int'(a_v), 1);

        // two edges into the divider before pausing, so two remain after resume
        @(negedge clk); @(negedge clk); #1;
        a_en = 1'b0;
        for (int i = 0; i < 37; i++) begin
            @(negedge clk); #1;
            chk("a_hold", int'({a_pix, a_hs, a_vs, a_vid, a_h, a_v}),
                int'({1'b0, 1'b1, 1'b1, 1'b1, 11'd300, 11'd1}));
        end
        for (int n = 1101; n <= 1700; n++) q_a.push_back(model_a(n));
        a_en = 1'b1;
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); edges++;
            @(negedge clk); #1;
            if (a_pix) break;
        end
        chk("a_resume_edges", edges, 2);

        for (int i = 0; i < 600 * 4 + 40 && q_a.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        chk("a_drain2", q_a.size(), 0);
        chk("a_hsync_low_pixels", a_hs_low, 96);
        chk("a_hsync_first", a_hs_first, 656);
        chk("a_hsync_last", a_hs_last, 751);
        chk("a_video_fall_h", a_vid_fall, 640);
        a_en = 1'b0;
    endtask

    task automatic run_b();
        int idle;
        b_rst = 1'b1; b_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("b_rst_state", int'({b_h, b_v, b_hs, b_vs, b_vid, b_pix, b_fs}), 0);

        for (int n = 1; n <= 320; n++) q_b.push_back(model_b(n));
        b_rst = 1'b0; b_en = 1'b1;
        idle = 0;
        for (int i = 0; i < 320; i++) begin
            @(negedge clk); #1;
            if (!b_pix) idle++;
        end
        chk("b_pix_en_idle", idle, 0);
        chk("b_drain1", q_b.size(), 0);
        chk("b_frame_starts", b_fs_cnt, 2);
        chk("b_vsync_pixels", b_vs_cnt, 60);

        for (int n = 321; n <= 417; n++) q_b.push_back(model_b(n));
        for (int i = 0; i < 200 && q_b.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        chk("b_drain2", q_b.size(), 0);
        chk("b_pre_rst_pos", int'({b_h, b_v}), int'({5'd12, 5'd7}));
        chk("b_pre_rst_vsync", int'(b_vs), 1);

        b_rst = 1'b1;
        @(negedge clk); #1;
        chk("b_midrst_state", int'({b_h, b_v, b_hs, b_vs, b_vid, b_pix, b_fs}), 0);

        for (int n = 1; n <= 5; n++) q_b.push_back(model_b(n));
        b_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
        end
        chk("b_drain3", q_b.size(), 0);
        b_en = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion by %0t expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            run_a();
            run_b();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running VGA raster timing generator. Divides the system clock into a pixel strobe and advances horizontal and vertical pixel counters. Decodes hsync, vsync and the active-video window. Sits directly upstream of the constant comparators and pixel logic, which consume `h_count`/`v_count` to place objects on screen.

## Interface
Parameters:
- `H_VISIBLE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: hsync width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_VISIBLE`, 480: visible lines
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync width, lines
- `V_BP`, 33: vertical back porch, lines
- `SYNC_POL`, 0: active level of both syncs (0 = active-low)
- `CLK_DIV`, 4: system clocks per pixel, ≥1
- `bitDim`, 11: counter width; H_TOTAL and V_TOTAL must be < 2^bitDim

Ports:
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run enable. When low, the divider and counters hold.
- `h_count` out bitDim: current pixel column
- `v_count` out bitDim: current line
- `hsync` out 1: horizontal sync, polarity set by SYNC_POL
- `vsync` out 1: vertical sync, polarity set by SYNC_POL
- `video_on` out 1: high inside the visible window
- `pix_en` out 1: one-clock strobe marking a new pixel position
- `frame_start` out 1: one-clock strobe at pixel (0,0)

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800). V_TOTAL is formed the same way (525).
- Divider `div`: counts 0..CLK_DIV-1 while `en` is high and wraps to 0. Internal `tick` = en && div==CLK_DIV-1.
- On a `tick` edge:
  - `h_count` increments. At H_TOTAL-1 it wraps to 0.
  - `v_count` increments only when `h_count` wraps. At V_TOTAL-1 it wraps to 0.
- Decode, evaluated on the next-state counter values so outputs register on the same edge as the counters:
  - `hsync` active when H_VISIBLE+H_FP ≤ h < H_VISIBLE+H_FP+H_SYNC (656..751)
  - `vsync` active when V_VISIBLE+V_FP ≤ v < V_VISIBLE+V_FP+V_SYNC (490..491)
  - `video_on` = h<H_VISIBLE && v<V_VISIBLE
- `pix_en` is high in the clock after each `tick` edge. With CLK_DIV=1 and `en` high it stays high continuously.
- `frame_start` = `pix_en` && counters == (0,0) following a wrap from (H_TOTAL-1, V_TOTAL-1).
- `en` low:
  - counters, `div` and sync levels freeze
  - `pix_en` and `frame_start` are 0
  - resuming continues from the frozen `div` value
- All counter arithmetic is unsigned, bitDim wide. Wrap is by explicit compare, never by overflow.

## Timing
- Reset values:
  - `div`, `h_count`, `v_count` = 0
  - `hsync`, `vsync` = inactive (~SYNC_POL)
  - `video_on`, `pix_en`, `frame_start` = 0
- Reset mid-frame takes effect at the next edge and overrides `tick`.
- After reset, the first `tick` occurs on the CLK_DIV-th edge with `en` high. Counters read (1,0) after that edge.
- Decoded outputs have zero added latency relative to the counters: values visible in a cycle always correspond to the `h_count`/`v_count` visible in that same cycle.
- Line wrap and frame wrap happen on the same edge: (799,524) → (0,0). `frame_start` rises in the following clock, coinciding with `pix_en`.
- `en` falling in the same cycle as `tick` suppresses the advance.

## Structure
- Shared package `vga_timing_pkg`: 640x480@60 constants (visible, porches, sync widths, totals) and derived totals, used as parameter defaults.
- Sub-module `vga_axis_counter`, instantiated twice (horizontal and vertical):
  - parameters: visible, FP, SYNC, BP, width
  - inputs: advance, reset
  - outputs: count, wrap flag, registered sync, registered visible-window decode
- Top level holds the divider, the chaining of the vertical advance from the horizontal wrap, and `frame_start`.

## Test plan
- Reset, then `en`=1, CLK_DIV=4: first `pix_en` in the 5th clock after release; `h_count`=1, `v_count`=0; `hsync`=1, `vsync`=1, `video_on`=1.
- Run one line: `hsync` low for exactly 96 pixels, starting at h=656 and ending after h=751; `video_on` falls at h=640; h wraps 799→0 and v goes 0→1 on the same edge.
- Run a full frame: `vsync` low for lines 490–491 only; `video_on`=0 for v≥480; exactly one `frame_start` per 420000 pixel strobes (800·525).
- Hold `en`=0 for 37 clocks mid-line at h=300: counters, syncs and `div` are unchanged and `pix_en`=0; after resume the next tick follows the remaining divider count.
- Assert `rst` at (700,491) with `vsync` active: next edge gives counters (0,0), syncs inactive, `video_on`=0.
- CLK_DIV=1: `pix_en` constantly high; one full frame takes 420000 clocks.
